pipe_hazard_ctrl: RTL and testbench

// - Parametrised hazard/forwarding controller for the MIPS pipeline; a single block replacing separate

---
 rtl/pipe_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipe_hazard_ctrl_if.sv | 33 +++
 rtl/pipe_hazard_ctrl_fwd_match.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 82 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_haz_pkg: scoreboard entry type, forward-select type and helpers shared by pipe_hazard_ctrl.
// Register fields are sized for the widest supported address; narrower RA_W is zero-extended.
package pipe_haz_pkg;
    localparam int RA_MAX = 8;
    localparam int FS_MAX = 4;
    localparam int FWD_NONE = 0;
    typedef logic [FS_MAX-1:0] fs_t;
    typedef logic [RA_MAX-1:0] ra_t;
    typedef struct packed {
        logic vld;
        logic regw;
        logic load;
        ra_t  rd;
        ra_t  rs;
        ra_t  rt;
    } sb_entry_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
        return r;
    endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID-stage instruction fields toward the hazard controller,
// stall/bubble, forward selects and perf counters back to the pipeline.
interface pipe_hazard_ctrl_if #(
    parameter int RA_W = 5,
    parameter int FS_W = 3
);
    logic            id_valid;
    logic [RA_W-1:0] id_rs;
    logic            id_rs_used;
    logic [RA_W-1:0] id_rt;
    logic            id_rt_used;
    logic [RA_W-1:0] id_rd;
    logic            id_regw;
    logic            id_memr;
    logic            id_branch;
    logic            flush_id;
    logic            stall;
    logic            bubble;
    logic [FS_W-1:0] fwd_ex_a;
    logic [FS_W-1:0] fwd_ex_b;
    logic [FS_W-1:0] fwd_id_a;
    logic [FS_W-1:0] fwd_id_b;
    logic [31:0]     stall_cnt;
    logic [31:0]     flush_cnt;
    modport master (
        output id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd, id_regw, id_memr, id_branch, flush_id,
        input  stall, bubble, fwd_ex_a, fwd_ex_b, fwd_id_a, fwd_id_b, stall_cnt, flush_cnt
    );
    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd, id_regw, id_memr, id_branch, flush_id,
        output stall, bubble, fwd_ex_a, fwd_ex_b, fwd_id_a, fwd_id_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// pipe_fwd_match: youngest of N scoreboard entries (global index OFS..OFS+N-1) writing register r,
// plus whether its result is already forwardable and whether it is a load.
module pipe_fwd_match import pipe_haz_pkg::*; #(
    parameter int N        = 3,
    parameter int OFS      = 0,
    parameter int LOAD_LAT = 1
) (
    input  logic [N-1:0] wr,
    input  logic [N-1:0] ld,
    input  ra_t  [N-1:0] rd,
    input  ra_t          r,
    input  logic         en,
    output logic         hit,
    output fs_t          k,
    output logic         avail,
    output logic         load
);
    always_comb begin
        hit = 1'b0;
        k = fs_t'(FWD_NONE);
        load = 1'b0;
        for (int i = N - 1; i >= 0; i--)
            if (en && r != '0 && wr[i] && rd[i] == r) begin
                hit = 1'b1;
                k = fs_t'(i + OFS);
                load = ld[i];
            end
        avail = hit && int'(k) >= (load ? 1 + LOAD_LAT : 1);
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboard-based load-use / branch-operand hazard detection with EX and ID forward selects.
// Define HAZ_PERF_CNT_EN to add saturating stall and flush cycle counters.
module pipe_hazard_ctrl import pipe_haz_pkg::*; #(
    parameter int RA_W     = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int FS_W     = 3
) (
    input logic               Clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
    sb_entry_t [DEPTH-1:0] sb;
    logic [DEPTH-1:0] wr, ld;
    ra_t  [DEPTH-1:0] rd;
    logic unused_rsrt;
    always_comb begin
        unused_rsrt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr[i] = sb[i].vld & sb[i].regw;
            ld[i] = sb[i].load;
            rd[i] = sb[i].rd;
            if (i > 0) unused_rsrt = unused_rsrt ^ (^{sb[i].rs, sb[i].rt});
        end
    end
    logic ea_hit, eb_hit, ia_hit, ib_hit, ea_av, eb_av, ia_av, ib_av, ea_ld, eb_ld, ia_ld, ib_ld;
    fs_t  ea_k, eb_k, ia_k, ib_k;
    ra_t  id_rs, id_rt;
    assign id_rs = ra_t'(bus.id_rs[RA_W-1:0]);
    assign id_rt = ra_t'(bus.id_rt[RA_W-1:0]);
    pipe_fwd_match #(.N(DEPTH - 1), .OFS(1), .LOAD_LAT(LOAD_LAT)) u_ex_a (
        .wr(wr[DEPTH-1:1]), .ld(ld[DEPTH-1:1]), .rd(rd[DEPTH-1:1]), .r(sb[0].rs), .en(sb[0].vld),
        .hit(ea_hit), .k(ea_k), .avail(ea_av), .load(ea_ld));
    pipe_fwd_match #(.N(DEPTH - 1), .OFS(1), .LOAD_LAT(LOAD_LAT)) u_ex_b (
        .wr(wr[DEPTH-1:1]), .ld(ld[DEPTH-1:1]), .rd(rd[DEPTH-1:1]), .r(sb[0].rt), .en(sb[0].vld),
        .hit(eb_hit), .k(eb_k), .avail(eb_av), .load(eb_ld));
    pipe_fwd_match #(.N(DEPTH), .OFS(0), .LOAD_LAT(LOAD_LAT)) u_id_a (
        .wr(wr), .ld(ld), .rd(rd), .r(id_rs), .en(bus.id_rs_used),
        .hit(ia_hit), .k(ia_k), .avail(ia_av), .load(ia_ld));
    pipe_fwd_match #(.N(DEPTH), .OFS(0), .LOAD_LAT(LOAD_LAT)) u_id_b (
        .wr(wr), .ld(ld), .rd(rd), .r(id_rt), .en(bus.id_rt_used),
        .hit(ib_hit), .k(ib_k), .avail(ib_av), .load(ib_ld));
    logic unused_ex;
    assign unused_ex = ^{ea_av, eb_av, ea_ld, eb_ld, unused_rsrt};
    // branches need the value in ID; ALU consumers only need a load to have reached its data stage
    logic ha, hb, st;
    assign ha = ia_hit & (bus.id_branch ? !ia_av : (ia_ld & (int'(ia_k) + 1 < 1 + LOAD_LAT)));
    assign hb = ib_hit & (bus.id_branch ? !ib_av : (ib_ld & (int'(ib_k) + 1 < 1 + LOAD_LAT)));
    assign st = bus.id_valid & (ha | hb) & !bus.flush_id;
    assign bus.stall    = st;
    assign bus.bubble   = st | bus.flush_id;
    assign bus.fwd_ex_a = ea_hit ? FS_W'(ea_k) : FS_W'(FWD_NONE);
    assign bus.fwd_ex_b = eb_hit ? FS_W'(eb_k) : FS_W'(FWD_NONE);
    assign bus.fwd_id_a = ia_av ? FS_W'(ia_k) : FS_W'(FWD_NONE);
    assign bus.fwd_id_b = ib_av ? FS_W'(ib_k) : FS_W'(FWD_NONE);
    sb_entry_t nxt;
    always_comb begin
        nxt = '0;
        if (bus.id_valid && !st && !bus.flush_id)
            nxt = '{vld: 1'b1, regw: bus.id_regw, load: bus.id_memr,
                    rd: ra_t'(bus.id_rd[RA_W-1:0]), rs: id_rs, rt: id_rt};
    end
    always_ff @(posedge Clk or negedge rst)
        if (!rst) sb <= '0;
        else sb <= {sb[DEPTH-2:0], nxt};
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
    always_ff @(posedge Clk or negedge rst)
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (st && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
            if (bus.flush_id && !(&flush_cnt)) flush_cnt <= flush_cnt + 32'd1;
        end
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table and randomized run on DEPTH=3/LOAD_LAT=1 against an issue-history model,
// plus DEPTH=5/LOAD_LAT=2 load-use and reset-mid-stall sequences.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0, rst3 = 1'b0, rst5 = 1'b0;
    always #5 clk = ~clk;
    pipe_hazard_ctrl_if #(.RA_W(5), .FS_W(3)) b3();
    pipe_hazard_ctrl_if #(.RA_W(5), .FS_W(3)) b5();
    pipe_hazard_ctrl #(.RA_W(5), .DEPTH(3), .LOAD_LAT(1), .FS_W(3)) u3 (.Clk(clk), .rst(rst3), .bus(b3));
    pipe_hazard_ctrl #(.RA_W(5), .DEPTH(5), .LOAD_LAT(2), .FS_W(3)) u5 (.Clk(clk), .rst(rst5), .bus(b5));
`ifdef HAZ_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic drive(input int u, input int v, rs, rsu, rt, rtu, rd, rw, ld, br, fl);
        if (u == 3) begin
            b3.id_valid = v != 0; b3.id_rs = 5'(rs); b3.id_rs_used = rsu != 0; b3.id_rt = 5'(rt);
            b3.id_rt_used = rtu != 0; b3.id_rd = 5'(rd); b3.id_regw = rw != 0; b3.id_memr = ld != 0;
            b3.id_branch = br != 0; b3.flush_id = fl != 0;
        end else begin
            b5.id_valid = v != 0; b5.id_rs = 5'(rs); b5.id_rs_used = rsu != 0; b5.id_rt = 5'(rt);
            b5.id_rt_used = rtu != 0; b5.id_rd = 5'(rd); b5.id_regw = rw != 0; b5.id_memr = ld != 0;
            b5.id_branch = br != 0; b5.flush_id = fl != 0;
        end
    endtask
    task automatic chk3(input string t, input int st, bb, exa, exb, ida, idb);
        chk({t, " stall"}, int'(b3.stall), st);
        chk({t, " bubble"}, int'(b3.bubble), bb);
        chk({t, " fwd_ex_a"}, int'(b3.fwd_ex_a), exa);
        chk({t, " fwd_ex_b"}, int'(b3.fwd_ex_b), exb);
        chk({t, " fwd_id_a"}, int'(b3.fwd_id_a), ida);
        chk({t, " fwd_id_b"}, int'(b3.fwd_id_b), idb);
    endtask
    // model: history of issued instructions; an instruction issued in cycle c sits k = now-c-1 stages past ID
    typedef struct { int regw, load, rd, rs, rt, cyc; } rec_t;
    rec_t q[$];
    int now;
    function automatic int youngest(input int r, input int lo, output int ld);
        ld = 0;
        if (r == 0) return -1;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (now - q[i].cyc - 1 >= lo && now - q[i].cyc - 1 < 3 && q[i].regw != 0 && q[i].rd == r) begin
                ld = q[i].load;
                return now - q[i].cyc - 1;
            end
        end
        return -1;
    endfunction
    function automatic bit ready(input int k, input int ld);
        return k >= 0 && k >= (ld != 0 ? 2 : 1);
    endfunction
    typedef struct { int v, rs, rsu, rt, rtu, rd, rw, ld, br, fl, st, bb, exa, exb, ida, idb; } vec_t;
    vec_t tbl[25];
    int exp_sc, exp_fc, v, rs, rsu, rt, rtu, rd, rw, ld, br, fl, ka, kb, la, lb, dl, est, exa, exb, e0;
    initial begin
        tbl[0]  = '{1,1,1,2,1,3,1,0,0,0,  0,0,0,0,0,0};
        tbl[1]  = '{1,3,1,1,1,4,1,0,0,0,  0,0,0,0,0,0};
        tbl[2]  = '{0,0,0,0,0,0,0,0,0,0,  0,0,1,0,0,0};
        tbl[3]  = '{0,0,0,0,0,0,0,0,0,0,  0,0,0,0,0,0};
        tbl[4]  = '{1,0,1,5,0,5,1,1,0,0,  0,0,0,0,0,0};
        tbl[5]  = '{1,5,1,5,1,6,1,0,0,0,  1,1,0,0,0,0};
        tbl[6]  = '{1,5,1,5,1,6,1,0,0,0,  0,0,0,0,0,0};
        tbl[7]  = '{0,0,0,0,0,0,0,0,0,0,  0,0,2,2,0,0};
        tbl[8]  = '{1,1,1,2,1,7,1,0,0,0,  0,0,0,0,0,0};
        tbl[9]  = '{1,7,1,0,1,0,0,0,1,0,  1,1,0,0,0,0};
        tbl[10] = '{1,7,1,0,1,0,0,0,1,0,  0,0,0,0,1,0};
        tbl[11] = '{0,0,0,0,0,0,0,0,0,0,  0,0,2,0,0,0};
        tbl[12] = '{1,0,1,8,0,8,1,1,0,0,  0,0,0,0,0,0};
        tbl[13] = '{1,8,1,0,1,0,0,0,1,0,  1,1,0,0,0,0};
        tbl[14] = '{1,8,1,0,1,0,0,0,1,0,  1,1,0,0,0,0};
        tbl[15] = '{1,8,1,0,1,0,0,0,1,0,  0,0,0,0,2,0};
        tbl[16] = '{0,0,0,0,0,0,0,0,0,0,  0,0,0,0,0,0};
        tbl[17] = '{1,1,1,1,1,0,1,0,0,0,  0,0,0,0,0,0};
        tbl[18] = '{1,0,1,0,1,9,1,0,0,0,  0,0,0,0,0,0};
        tbl[19] = '{0,0,0,0,0,0,0,0,0,0,  0,0,0,0,0,0};
        tbl[20] = '{1,0,1,10,0,10,1,1,0,0, 0,0,0,0,0,0};
        tbl[21] = '{1,10,1,0,1,11,1,0,0,1, 0,1,0,0,0,0};
        tbl[22] = '{1,11,1,0,1,0,0,0,1,0, 0,0,0,0,0,0};
        tbl[23] = '{1,0,1,13,0,13,1,1,0,0, 0,0,0,0,0,0};
        tbl[24] = '{1,13,0,13,0,0,0,0,1,0, 0,0,0,0,0,0};
        drive(3, 0,0,0,0,0,0,0,0,0,0);
        drive(5, 0,0,0,0,0,0,0,0,0,0);
        repeat (2) @(negedge clk);
        chk3("reset", 0, 0, 0, 0, 0, 0);
        chk("reset stall_cnt", int'(b3.stall_cnt), 0);
        chk("reset flush_cnt", int'(b3.flush_cnt), 0);
        rst3 = 1'b1;
        rst5 = 1'b1;
        @(posedge clk); #1;
        exp_sc = 0;
        exp_fc = 0;
        for (int i = 0; i < 25; i++) begin
            drive(3, tbl[i].v, tbl[i].rs, tbl[i].rsu, tbl[i].rt, tbl[i].rtu, tbl[i].rd, tbl[i].rw,
                  tbl[i].ld, tbl[i].br, tbl[i].fl);
            @(negedge clk);
            chk3($sformatf("row%0d", i), tbl[i].st, tbl[i].bb, tbl[i].exa, tbl[i].exb, tbl[i].ida, tbl[i].idb);
            exp_sc += tbl[i].st;
            exp_fc += tbl[i].fl;
            @(posedge clk); #1;
        end
        chk("table stall_cnt", int'(b3.stall_cnt), CNT_EN ? exp_sc : 0);
        chk("table flush_cnt", int'(b3.flush_cnt), CNT_EN ? exp_fc : 0);
        drive(3, 0,0,0,0,0,0,0,0,0,0);
        @(negedge clk) rst3 = 1'b0;
        @(negedge clk) rst3 = 1'b1;
        @(posedge clk); #1;
        q.delete();
        now = 0;
        exp_sc = 0;
        exp_fc = 0;
        est = 0;
        for (int n = 0; n < 1500; n++) begin
            if (est == 0) begin
                v = ($urandom_range(0, 7) != 0); rs = $urandom_range(0, 3); rsu = $urandom_range(0, 1);
                rt = $urandom_range(0, 3); rtu = $urandom_range(0, 1); rd = $urandom_range(0, 3);
                rw = $urandom_range(0, 1); ld = rw != 0 && $urandom_range(0, 2) == 0;
                br = ($urandom_range(0, 3) == 0);
            end
            fl = ($urandom_range(0, 9) == 0);
            drive(3, v, rs, rsu, rt, rtu, rd, rw, ld, br, fl);
            @(negedge clk);
            ka = rsu != 0 ? youngest(rs, 0, la) : -1;
            kb = rtu != 0 ? youngest(rt, 0, lb) : -1;
            est = v != 0 && fl == 0 &&
                  ((ka >= 0 && (br != 0 ? !ready(ka, la) : (la != 0 && ka + 1 < 2))) ||
                   (kb >= 0 && (br != 0 ? !ready(kb, lb) : (lb != 0 && kb + 1 < 2))));
            exa = 0;
            exb = 0;
            e0 = -1;
            for (int i = 0; i < q.size(); i++) if (q[i].cyc == now - 1) e0 = i;
            if (e0 >= 0) begin
                exa = youngest(q[e0].rs, 1, dl);
                exb = youngest(q[e0].rt, 1, dl);
            end
            chk3($sformatf("rnd%0d", n), est, (est != 0 || fl != 0) ? 1 : 0, exa < 0 ? 0 : exa,
                 exb < 0 ? 0 : exb, ready(ka, la) ? ka : 0, ready(kb, lb) ? kb : 0);
            exp_sc += est;
            exp_fc += fl;
            if (v != 0 && est == 0 && fl == 0) q.push_back('{rw, ld, rd, rs, rt, now});
            now++;
            while (q.size() > 0 && now - q[0].cyc - 1 >= 3) void'(q.pop_front());
            @(posedge clk); #1;
        end
        chk("rnd stall_cnt", int'(b3.stall_cnt), CNT_EN ? exp_sc : 0);
        chk("rnd flush_cnt", int'(b3.flush_cnt), CNT_EN ? exp_fc : 0);
        // DEPTH=5, LOAD_LAT=2: load-use costs two stalls, then EX forwards from entry 3
        drive(5, 1,0,1,5,0,5,1,1,0,0);
        @(negedge clk);
        chk("d5 lw stall", int'(b5.stall), 0);
        @(posedge clk); #1;
        drive(5, 1,5,1,5,1,6,1,0,0,0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("d5 use%0d stall", i), int'(b5.stall), i < 2 ? 1 : 0);
            chk($sformatf("d5 use%0d bubble", i), int'(b5.bubble), i < 2 ? 1 : 0);
            @(posedge clk); #1;
        end
        drive(5, 0,0,0,0,0,0,0,0,0,0);
        @(negedge clk);
        chk("d5 fwd_ex_a", int'(b5.fwd_ex_a), 3);
        chk("d5 fwd_ex_b", int'(b5.fwd_ex_b), 3);
        @(posedge clk); #1;
        drive(5, 1,0,1,9,0,9,1,1,0,0);
        @(posedge clk); #1;
        drive(5, 1,9,1,0,0,10,1,0,0,0);
        @(negedge clk);
        chk("d5 pre-rst stall", int'(b5.stall), 1);
        #2 rst5 = 1'b0;
        #1;
        chk("d5 rst stall", int'(b5.stall), 0);
        chk("d5 rst bubble", int'(b5.bubble), 0);
        chk("d5 rst fwd_id_a", int'(b5.fwd_id_a), 0);
        chk("d5 rst fwd_ex_a", int'(b5.fwd_ex_a), 0);
        @(negedge clk) rst5 = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
